// File: rtl/comparador_serial_der_izq_pkg.sv
// rtl/comparador_serial_der_izq_pkg.sv - shared state and result codes for the serial comparator
package comparador_serial_der_izq_pkg;

    // FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // (f,g) result codes; 2'b11 is never produced
    localparam logic [1:0] RES_EQ = 2'b00;
    localparam logic [1:0] RES_GT = 2'b10;
    localparam logic [1:0] RES_LT = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_e;

endpackage

// File: rtl/comparador_serial_der_izq_celda.sv
// rtl/comparador_serial_der_izq_celda.sv - right-to-left comparator cell for one digit pair
import comparador_serial_der_izq_pkg::*;

module celda_der_izq #(
    parameter int DIGIT_W = 3
) (
    input  logic               f_in,
    input  logic               g_in,
    input  logic [DIGIT_W-1:0] A,
    input  logic [DIGIT_W-1:0] B,
    output logic               f_mid,
    output logic               g_mid
);

    logic [1:0] fg_mid;

    // A more significant digit that differs overrides the lower-digit decision;
    // equal digits pass the incoming decision through unchanged.
    always_comb begin
        fg_mid = {f_in, g_in};
        if (A > B) begin
            fg_mid = RES_GT;
        end else if (A < B) begin
            fg_mid = RES_LT;
        end
    end

    assign f_mid = fg_mid[1];
    assign g_mid = fg_mid[0];

endmodule

// File: rtl/comparador_serial_der_izq.sv
// rtl/comparador_serial_der_izq.sv - bit-serial LSB-first magnitude comparator
import comparador_serial_der_izq_pkg::*;

module comparador_serial_der_izq #(
    parameter int DIGIT_W  = 3,
    parameter int N_DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT_W-1:0] A,
    input  logic [DIGIT_W-1:0] B,
    output logic               busy,
    output logic               done,
    output logic               f_out,
    output logic               g_out
);

    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fg_q, fg_d;
    logic [1:0]       res_q, res_d;
    logic             f_mid, g_mid;
    logic             accept;

    celda_der_izq #(
        .DIGIT_W (DIGIT_W)
    ) u_celda (
        .f_in  (fg_q[1]),
        .g_in  (fg_q[0]),
        .A     (A),
        .B     (B),
        .f_mid (f_mid),
        .g_mid (g_mid)
    );

    // Handshake outputs depend only on state so in_ready never sees in_valid.
    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign f_out    = res_q[1];
    assign g_out    = res_q[0];
    assign accept   = in_valid && in_ready;

    // Next-state, digit counter, running decision and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fg_d    = fg_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    fg_d    = RES_EQ;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    fg_d  = {f_mid, g_mid};
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        // Load the result now so it is visible in the done cycle.
                        state_d = ST_DONE;
                        res_d   = {f_mid, g_mid};
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, decision and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fg_q    <= RES_EQ;
            res_q   <= RES_EQ;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fg_q    <= fg_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// tb/tb_comparador_serial_der_izq.sv - self-checking bench for the serial comparator
module tb_comparador_serial_der_izq;

    localparam int DW = 3;
    localparam int ND = 4;
    localparam int OW = DW * ND;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a_dig;
    logic [DW-1:0] b_dig;
    logic          busy;
    logic          done;
    logic          f_out;
    logic          g_out;

    comparador_serial_der_izq #(
        .DIGIT_W  (DW),
        .N_DIGITS (ND)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (a_dig),
        .B        (b_dig),
        .busy     (busy),
        .done     (done),
        .f_out    (f_out),
        .g_out    (g_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic          f;
        logic          g;
    } vec_t;

    typedef struct {
        logic f;
        logic g;
        int   due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   dones = 0;
    int   dones_expected = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.due);
                check("f_out", {31'd0, f_out}, {31'd0, mon_e.f});
                check("g_out", {31'd0, g_out}, {31'd0, mon_e.g});
            end
        end
    end

    // One comparison; optional stall of stall_len cycles before digit index stall_at,
    // with start held high and junk digits presented during the stall.
    task automatic run_cmp(input logic [OW-1:0] a, input logic [OW-1:0] b,
                           input logic ef, input logic eg,
                           input int stall_at, input int stall_len);
        exp_t e;
        int   extra;
        extra = (stall_at >= 0) ? stall_len : 0;
        start = 1'b1;
        e.f   = ef;
        e.g   = eg;
        e.due = cyc + ND + 1 + extra;
        sb.push_back(e);
        dones_expected++;
        step;
        start = 1'b0;
        for (int d = 0; d < ND; d++) begin
            if (d == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    in_valid = 1'b0;
                    start    = 1'b1;
                    a_dig    = DW'($urandom);
                    b_dig    = DW'($urandom);
                    step;
                end
            end
            start    = 1'b0;
            in_valid = 1'b1;
            a_dig    = a[d*DW +: DW];
            b_dig    = b[d*DW +: DW];
            check("in_ready_run", {31'd0, in_ready}, 32'd1);
            step;
        end
        in_valid = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        step;
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    vec_t vecs[4];
    logic [OW-1:0] ra, rb;
    int   dones_before;

    initial begin
        vecs[0] = '{a: 12'o1234, b: 12'o1234, f: 1'b0, g: 1'b0};
        vecs[1] = '{a: 12'o2000, b: 12'o1777, f: 1'b1, g: 1'b0};
        vecs[2] = '{a: 12'o0005, b: 12'o0006, f: 1'b0, g: 1'b1};
        vecs[3] = '{a: 12'o0700, b: 12'o7000, f: 1'b0, g: 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        a_dig    = '0;
        b_dig    = '0;
        repeat (2) step;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_f_out", {31'd0, f_out}, 32'd0);
        check("rst_g_out", {31'd0, g_out}, 32'd0);
        rst_n = 1'b1;
        step;

        // Table vectors, each followed by idle cycles to confirm the result holds.
        for (int i = 0; i < 4; i++) begin
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].g, -1, 0);
            repeat (3) step;
            check("hold_f", {31'd0, f_out}, {31'd0, vecs[i].f});
            check("hold_g", {31'd0, g_out}, {31'd0, vecs[i].g});
            check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        end

        // Stalls with start pulsed during RUN: one done, two cycles late.
        dones_before = dones;
        run_cmp(12'o7000, 12'o6777, 1'b1, 1'b0, 2, 2);
        repeat (3) step;
        check("stall_single_done", dones - dones_before, 32'd1);

        // Reset after two accepted digits aborts and clears the held result.
        dones_before = dones;
        start = 1'b1;
        step;
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid = 1'b1;
            a_dig    = 3'd7;
            b_dig    = 3'd1;
            step;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step;
        rst_n = 1'b1;
        check("abort_f_out", {31'd0, f_out}, 32'd0);
        check("abort_g_out", {31'd0, g_out}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (6) step;
        check("abort_no_done", dones - dones_before, 32'd0);
        run_cmp(12'o0000, 12'o0001, 1'b0, 1'b1, -1, 0);

        // Back-to-back: start in the IDLE cycle right after done.
        run_cmp(12'o7777, 12'o7776, 1'b1, 1'b0, -1, 0);
        run_cmp(12'o0100, 12'o0100, 1'b0, 1'b0, -1, 0);

        // Random operands checked against integer magnitude comparison.
        for (int i = 0; i < 6; i++) begin
            ra = OW'($urandom);
            rb = (i % 3 == 0) ? ra : OW'($urandom);
            run_cmp(ra, rb, ra > rb, ra < rb, (i % 2 == 0) ? i % ND : -1, 1 + i % 3);
        end

        repeat (3) step;
        check("scoreboard_empty", sb.size(), 32'd0);
        check("done_count", dones, dones_expected);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
